// File: rtl/intt_controller.sv
// intt_controller: sequences one intt_core through the data load and all inverse-NTT stages
module intt_controller #(
    parameter int LOG_N          = 12,
    parameter int LOG_CORE_COUNT = 4,
    parameter int ADDR_WIDTH     = 9,
    parameter int PIPE_LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            log_m,
    output logic [9:0]            i,
    output logic [1:0]            mode,
    output logic [ADDR_WIDTH-1:0] upper_read_address,
    output logic [ADDR_WIDTH-1:0] lower_read_address,
    output logic [ADDR_WIDTH-1:0] upper_write_address,
    output logic [ADDR_WIDTH-1:0] lower_write_address,
    output logic                  upper_write_enable,
    output logic                  lower_write_enable,
    output logic                  write_select,
    output logic                  read_select,
    output logic                  input_select
);
    localparam int SW = $clog2(LOG_N + 1);
    localparam int AW = ADDR_WIDTH;
    localparam int PL = PIPE_LATENCY;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_STAGE = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_SWAP  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d, rc_q, rc_d;
    logic [SW-1:0]         s_q, s_d;
    logic                  rs_q, rs_d;
    logic [PL-1:0]         we_q, we_d;
    logic [PL-1:0][AW-1:0] wa_q, wa_d;
    logic                  last_stage, in_stage, load;
    int                    lm;

    // next-state logic; cnt counts loaded words in LOAD and write-back cycles in DRAIN
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rc_d       = rc_q;
        s_d        = s_q;
        rs_d       = rs_q;
        we_d       = {we_q[PL-2:0], state_q == ST_STAGE};
        wa_d       = {wa_q[PL-2:0], rc_q};
        last_stage = s_q == SW'(LOG_N - 1);
        case (state_q)
            ST_IDLE:  state_d = start ? ST_LOAD : ST_IDLE;
            ST_LOAD: if (in_valid) begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d = ST_STAGE;
                    rs_d    = 1'b1;
                end
            end
            ST_STAGE: begin
                rc_d    = rc_q + 1'b1;
                state_d = &rc_q ? ST_DRAIN : ST_STAGE;
            end
            ST_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(PL - 1)) begin
                    cnt_d   = '0;
                    state_d = last_stage ? ST_DONE : ST_SWAP;
                    rs_d    = last_stage ? ~rs_q : rs_q;
                end
            end
            ST_SWAP: begin
                rs_d    = ~rs_q;
                s_d     = s_q + 1'b1;
                state_d = ST_STAGE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                rs_d    = 1'b0;
                s_d     = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            rc_d    = '0;
            s_d     = '0;
            rs_d    = 1'b0;
            we_d    = '0;
            wa_d    = '0;
        end
    end

    // state and write-back delay line registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rc_q    <= '0;
            s_q     <= '0;
            rs_q    <= 1'b0;
            we_q    <= '0;
            wa_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
            s_q     <= s_d;
            rs_q    <= rs_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
        end
    end

    // core control outputs decoded from state so reset clears them without waiting for an edge
    always_comb begin
        load                = state_q == ST_LOAD;
        in_stage            = state_q == ST_STAGE || state_q == ST_DRAIN || state_q == ST_SWAP;
        lm                  = in_stage ? LOG_N - int'(s_q) : LOG_N;
        log_m               = 4'(lm);
        mode                = !in_stage ? 2'd0 : lm >= AW + 2 ? 2'd0 : lm >= LOG_CORE_COUNT + 2 ? 2'd1 : 2'd2;
        i                   = 10'({1'b0, rc_q} >> s_q);
        busy                = in_stage || load;
        done                = state_q == ST_DONE;
        upper_read_address  = rc_q;
        lower_read_address  = rc_q;
        upper_write_address = load ? cnt_q : wa_q[PL-1];
        lower_write_address = load ? cnt_q : wa_q[PL-1];
        upper_write_enable  = load ? in_valid : we_q[PL-1];
        lower_write_enable  = load ? in_valid : we_q[PL-1];
        write_select        = (state_q == ST_IDLE || load) ? 1'b1 : ~rs_q;
        read_select         = rs_q;
        input_select        = load;
    end
endmodule
